tdm_demux4: RTL and testbench

Time-division 1-to-4 demultiplexer, the receive-side counterpart of the team's 4:1 mux. It takes a single serial sample stream in which slot k carries lane k, using the same mapping as the mux select value S=k. It rebuilds the four lanes into one parallel registered word and emits a one-cycle frame strobe. It sits after the mux/link stage and restores the original D vector for downstream logic.

---
 rtl/tdm_demux_pkg.sv | 16 +
 rtl/tdm_demux4.sv | 98 +++++++++
 tb/tb_tdm_demux4.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared constants, state type and lane-slice helper for the TDM 1-to-4 demultiplexer.
package tdm_demux_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned SLOT_W = 2;

    typedef enum logic {
        HUNT,
        COLLECT
    } state_e;

    function automatic int unsigned lane_offset(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/tdm_demux4.sv
// Time-division 1-to-4 demultiplexer: rebuilds four serial slots into one registered frame
// and pulses out_valid when a frame completes, sync_err when sync arrives mid-frame.
module tdm_demux4
    import tdm_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    input  logic                     in_sync,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic                     out_valid,
    output logic [SLOT_W-1:0]        out_sel,
    output logic                     sync_err
);

    state_e                  state_q, state_d;
    logic [SLOT_W-1:0]       sel_q, sel_d;
    logic [LANES*WIDTH-1:0]  out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sync_err_q, sync_err_d;

    // Lane 3 is never shadowed: it is taken straight from the input when the frame closes.
    logic [WIDTH-1:0]        shadow_q [0:LANES-2];
    logic [WIDTH-1:0]        shadow_d [0:LANES-2];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (in_valid && in_sync) begin
                    shadow_d[0] = in_data;
                    sel_d       = SLOT_W'(1);
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    if (in_sync && (sel_q != '0)) begin
                        // Sync mid-frame: drop the partial frame and restart at slot 0.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = in_data;
                        sel_d       = SLOT_W'(1);
                    end else if (sel_q == SLOT_W'(LANES - 1)) begin
                        for (int k = 0; k < LANES - 1; k++) begin
                            out_data_d[lane_offset(k, WIDTH) +: WIDTH] = shadow_q[k];
                        end
                        out_data_d[lane_offset(LANES - 1, WIDTH) +: WIDTH] = in_data;
                        out_valid_d = 1'b1;
                        sel_d       = '0;
                    end else begin
                        for (int k = 0; k < LANES - 1; k++) begin
                            if (sel_q == SLOT_W'(k)) begin
                                shadow_d[k] = in_data;
                            end
                        end
                        sel_d = sel_q + SLOT_W'(1);
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            sel_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            for (int k = 0; k < LANES - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            shadow_q    <= shadow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = sel_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: drives WIDTH=1 and WIDTH=8 instances from one stream and checks both
// against a queue-based frame model after every clock.
module tb_tdm_demux4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sync;

    logic [3:0]  out_data1;
    logic        out_valid1;
    logic [1:0]  out_sel1;
    logic        sync_err1;
    logic [31:0] out_data8;
    logic        out_valid8;
    logic [1:0]  out_sel8;
    logic        sync_err8;

    int checks = 0;
    int errors = 0;

    // Model: lock flag plus the samples of the frame in progress.
    bit          m_locked;
    logic [7:0]  m_q[$];
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_err;

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data[0]),
        .in_valid (in_valid),
        .in_sync  (in_sync),
        .out_data (out_data1),
        .out_valid(out_valid1),
        .out_sel  (out_sel1),
        .sync_err (sync_err1)
    );

    tdm_demux4 #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_sync  (in_sync),
        .out_data (out_data8),
        .out_valid(out_valid8),
        .out_sel  (out_sel8),
        .sync_err (sync_err8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic [7:0] d, input logic v,
                                input logic s);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_q.delete();
            m_data = '0;
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1'b1;
                    m_q = {d};
                end
            end else if (s && m_q.size() != 0) begin
                m_err = 1'b1;
                m_q = {d};
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    m_data  = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_valid = 1'b1;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        logic [1:0] esel;
        esel = 2'(m_q.size());
        chk("data8",  out_data8, m_data);
        chk("data1",  {28'd0, out_data1}, {28'd0, m_data[24], m_data[16], m_data[8], m_data[0]});
        chk("valid8", {31'd0, out_valid8}, {31'd0, m_valid});
        chk("valid1", {31'd0, out_valid1}, {31'd0, m_valid});
        chk("err8",   {31'd0, sync_err8}, {31'd0, m_err});
        chk("err1",   {31'd0, sync_err1}, {31'd0, m_err});
        chk("sel8",   {30'd0, out_sel8}, {30'd0, esel});
        chk("sel1",   {30'd0, out_sel1}, {30'd0, esel});
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [7:0] d, input logic v, input logic s);
        rst = r; in_data = d; in_valid = v; in_sync = s;
        @(posedge clk);
        model_update(r, d, v, s);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] e, input int gap);
        step(1'b0, a, 1'b1, 1'b1); idle(gap);
        step(1'b0, b, 1'b1, 1'b0); idle(gap);
        step(1'b0, c, 1'b1, 1'b0); idle(gap);
        step(1'b0, e, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sync = 1'b0;
        m_locked = 1'b0; m_data = '0; m_valid = 1'b0; m_err = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b1, 8'h00, 1'b0, 1'b0);
        chk("rst_data", out_data8, 32'h0);

        // Frame 1,1,1,0 -> 0111 strobed after the 4th sample
        frame(8'h01, 8'h01, 8'h01, 8'h00, 0);
        chk("f1_data", {28'd0, out_data1}, 32'h7);
        chk("f1_strobe", {31'd0, out_valid1}, 32'h1);
        idle(1);
        chk("f1_pulse_end", {31'd0, out_valid1}, 32'h0);

        // Unsynced samples in HUNT are ignored
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h01, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h01, 1'b1, 1'b0);
        step(1'b0, 8'h01, 1'b1, 1'b0);
        chk("hunt_sel", {30'd0, out_sel1}, 32'h0);
        frame(8'h00, 8'h00, 8'h00, 8'h01, 0);
        chk("f2_data", {28'd0, out_data1}, 32'h8);

        // Gapped frame; output holds across gaps
        frame(8'h01, 8'h00, 8'h01, 8'h00, 3);
        chk("f3_data", {28'd0, out_data1}, 32'h5);
        idle(3);
        chk("f3_hold", {28'd0, out_data1}, 32'h5);

        // Sync at slot 2 restarts the frame
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h01, 1'b1, 1'b1);
        chk("serr_pulse", {31'd0, sync_err1}, 32'h1);
        chk("serr_hold", {28'd0, out_data1}, 32'h5);
        step(1'b0, 8'h01, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("f4_data", {28'd0, out_data1}, 32'h3);

        // Back-to-back frames
        frame(8'h00, 8'h01, 8'h01, 8'h01, 0);
        chk("f5_data", {28'd0, out_data1}, 32'hE);
        frame(8'h01, 8'h00, 8'h00, 8'h00, 0);
        chk("f6_data", {28'd0, out_data1}, 32'h1);

        // Reset mid-frame, then relock with a WIDTH=8 frame
        step(1'b0, 8'h05, 1'b1, 1'b1);
        step(1'b0, 8'h06, 1'b1, 1'b0);
        step(1'b1, 8'h07, 1'b1, 1'b0);
        chk("mid_rst_data", out_data8, 32'h0);
        step(1'b0, 8'h09, 1'b1, 1'b0);
        step(1'b0, 8'h0A, 1'b1, 1'b0);
        frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
        chk("f8_data", out_data8, 32'h44332211);
        chk("f8_data1", {28'd0, out_data1}, 32'h5);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) == 0), 8'($urandom),
                 ($urandom_range(99) < 70), ($urandom_range(99) < 15));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
